// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises N upstream memory clients onto one L2 port.
// One transaction at a time, with fixed-priority or round-robin selection.
// Every transaction passes IDLE (arbitrate) -> BUSY (forward) -> DRAIN (dead cycle).
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RR_MODE   = 1,
  localparam int BE_W     = DATA_W / 8,
  localparam int GW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*BE_W-1:0]   req_byte_enable,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic [ADDR_W-1:0]           l2_address,
  output logic [DATA_W-1:0]           l2_wdata,
  output logic                        l2_read,
  output logic                        l2_write,
  output logic [BE_W-1:0]             l2_byte_enable,
  input  logic [DATA_W-1:0]           l2_rdata,
  input  logic                        l2_resp,
  output logic [GW-1:0]               grant_id,
  output logic                        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] req_any;
  logic                 win_found;
  logic [GW-1:0]        win_idx;
  logic [GW-1:0]        cand;

  assign req_any = req_read | req_write;

  // Winner search: lowest index (fixed) or first index at/after rr_ptr with wrap (RR).
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the block can infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (RR_MODE != 0) cand = GW'((int'(rr_ptr_q) + k) % NUM_PORTS);
      else              cand = GW'(k);
      if (!win_found && req_any[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic for the FSM, the registered grant and the round-robin pointer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_BUSY;
          grant_d = win_idx;
        end
      end
      S_BUSY: begin
        // A request dropped mid-transaction still waits for l2_resp; L2 is committed.
        if (l2_resp) begin
          state_d = S_DRAIN;
          if (RR_MODE != 0)
            rr_ptr_d = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + GW'(1);
        end
      end
      S_DRAIN: begin
        // Grant is held through the dead cycle and cleared as IDLE is entered.
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; asynchronous reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Downstream mux and response steering; everything reads 0 outside BUSY.
  always_comb begin
    l2_address     = '0;
    l2_wdata       = '0;
    l2_byte_enable = '0;
    l2_read        = 1'b0;
    l2_write       = 1'b0;
    req_resp       = '0;
    req_rdata      = '0;
    if (state_q == S_BUSY) begin
      l2_address     = req_address[int'(grant_q)*ADDR_W +: ADDR_W];
      l2_wdata       = req_wdata[int'(grant_q)*DATA_W +: DATA_W];
      l2_byte_enable = req_byte_enable[int'(grant_q)*BE_W +: BE_W];
      l2_write       = req_write[grant_q];
      // Illegal read+write collapses to a write so L2 never sees both strobes.
      l2_read        = req_read[grant_q] & ~req_write[grant_q];
      if (l2_resp) begin
        req_resp[grant_q] = 1'b1;
        req_rdata         = l2_rdata;
      end
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
// Three instances: 2-port round-robin and 2-port fixed priority share stimulus,
// plus a 3-port round-robin for the wrap-around case.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk;
  logic reset;

  // Shared stimulus for the two 2-port instances.
  logic [2*AW-1:0] addr2;
  logic [2*DW-1:0] wdata2;
  logic [1:0]      rd2, wr2;
  logic [3:0]      be2;
  logic [DW-1:0]   l2_rdata2;
  logic            l2_resp2;

  logic [DW-1:0] rdata_a, rdata_b;
  logic [1:0]    resp_a, resp_b;
  logic [AW-1:0] l2_addr_a, l2_addr_b;
  logic [DW-1:0] l2_wdata_a, l2_wdata_b;
  logic          l2_read_a, l2_read_b, l2_write_a, l2_write_b;
  logic [1:0]    l2_be_a, l2_be_b;
  logic [0:0]    grant_a, grant_b;
  logic          busy_a, busy_b;

  // 3-port instance.
  logic [3*AW-1:0] addr3;
  logic [3*DW-1:0] wdata3;
  logic [2:0]      rd3, wr3;
  logic [5:0]      be3;
  logic [DW-1:0]   l2_rdata3;
  logic            l2_resp3;
  logic [DW-1:0]   rdata_c;
  logic [2:0]      resp_c;
  logic [AW-1:0]   l2_addr_c;
  logic [DW-1:0]   l2_wdata_c;
  logic            l2_read_c, l2_write_c;
  logic [1:0]      l2_be_c;
  logic [1:0]      grant_c;
  logic            busy_c;

  int checks = 0;
  int errors = 0;
  int cnt2, cnt3;

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) u_rr2 (
    .clk(clk), .reset(reset),
    .req_address(addr2), .req_wdata(wdata2), .req_read(rd2), .req_write(wr2),
    .req_byte_enable(be2), .req_rdata(rdata_a), .req_resp(resp_a),
    .l2_address(l2_addr_a), .l2_wdata(l2_wdata_a), .l2_read(l2_read_a),
    .l2_write(l2_write_a), .l2_byte_enable(l2_be_a), .l2_rdata(l2_rdata2),
    .l2_resp(l2_resp2), .grant_id(grant_a), .busy(busy_a)
  );

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) u_fx2 (
    .clk(clk), .reset(reset),
    .req_address(addr2), .req_wdata(wdata2), .req_read(rd2), .req_write(wr2),
    .req_byte_enable(be2), .req_rdata(rdata_b), .req_resp(resp_b),
    .l2_address(l2_addr_b), .l2_wdata(l2_wdata_b), .l2_read(l2_read_b),
    .l2_write(l2_write_b), .l2_byte_enable(l2_be_b), .l2_rdata(l2_rdata2),
    .l2_resp(l2_resp2), .grant_id(grant_b), .busy(busy_b)
  );

  mem_arbiter #(.NUM_PORTS(3), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) u_rr3 (
    .clk(clk), .reset(reset),
    .req_address(addr3), .req_wdata(wdata3), .req_read(rd3), .req_write(wr3),
    .req_byte_enable(be3), .req_rdata(rdata_c), .req_resp(resp_c),
    .l2_address(l2_addr_c), .l2_wdata(l2_wdata_c), .l2_read(l2_read_c),
    .l2_write(l2_write_c), .l2_byte_enable(l2_be_c), .l2_rdata(l2_rdata3),
    .l2_resp(l2_resp3), .grant_id(grant_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge (outputs settled, responder updated).
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) for a response pulse on instance sel: 0 = 2-port pair, 1 = 3-port.
  task automatic wait_resp(input int sel, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (sel == 0) seen = (resp_a != 2'b00);
      else          seen = (resp_c != 3'b000);
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // L2 model for the 2-port pair: responds in the third cycle of an active request.
  initial begin
    l2_resp2  = 1'b0;
    l2_rdata2 = 16'hBEEF;
    cnt2      = 0;
    forever begin
      @(negedge clk);
      if (reset || !(l2_read_a || l2_write_a)) begin
        cnt2     = 0;
        l2_resp2 = 1'b0;
      end else begin
        cnt2++;
        l2_resp2 = (cnt2 == 3);
      end
    end
  end

  // Same L2 model for the 3-port instance.
  initial begin
    l2_resp3  = 1'b0;
    l2_rdata3 = 16'hC0DE;
    cnt3      = 0;
    forever begin
      @(negedge clk);
      if (reset || !(l2_read_c || l2_write_c)) begin
        cnt3     = 0;
        l2_resp3 = 1'b0;
      end else begin
        cnt3++;
        l2_resp3 = (cnt3 == 3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    addr2 = '0; wdata2 = '0; rd2 = '0; wr2 = '0; be2 = '0;
    addr3 = '0; wdata3 = '0; rd3 = '0; wr3 = '0; be3 = '0;
    tick(); tick();

    // Reset state
    check("rst_busy",   32'(busy_a), 0);
    check("rst_grant",  32'(grant_a), 0);
    check("rst_l2_rd",  32'(l2_read_a), 0);
    check("rst_l2_wr",  32'(l2_write_a), 0);
    check("rst_resp",   32'(resp_a), 0);
    check("rst_rdata",  32'(rdata_a), 0);
    check("rst_l2_adr", 32'(l2_addr_a), 0);
    check("rst_grant3", 32'(grant_c), 0);
    reset = 1'b0;
    tick();

    // Both ports request continuously: RR alternates, fixed starves port 1
    addr2 = {16'h2222, 16'h1111};
    rd2   = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_resp(0, "rr_wait");
      check("rr_grant", 32'(grant_a), 32'(i % 2));
      check("rr_resp",  32'(resp_a), (i % 2) ? 32'd2 : 32'd1);
      check("fx_grant", 32'(grant_b), 0);
      check("fx_resp",  32'(resp_b), 1);
    end
    rd2[0] = 1'b0;
    wait_resp(0, "fx_release_wait");
    check("fx_grant_release", 32'(grant_b), 1);
    check("fx_resp_release",  32'(resp_b), 2);
    rd2 = '0;
    tick(); tick();

    // Single read from port 0, L2 latency 3
    addr2 = {16'h0000, 16'h1234};
    rd2   = 2'b01;
    #1;
    check("rd_arb_cycle_l2_rd", 32'(l2_read_a), 0);
    tick();
    check("rd_l2_read",  32'(l2_read_a), 1);
    check("rd_l2_addr",  32'(l2_addr_a), 32'h1234);
    check("rd_busy",     32'(busy_a), 1);
    check("rd_resp_c1",  32'(resp_a), 0);
    tick();
    check("rd_resp_c2",  32'(resp_a), 0);
    tick();
    check("rd_resp",     32'(resp_a), 1);
    check("rd_rdata",    32'(rdata_a), 32'hBEEF);
    check("rd_busy_rsp", 32'(busy_a), 1);
    rd2 = '0;
    tick();
    check("rd_drain_resp",  32'(resp_a), 0);
    check("rd_drain_rdata", 32'(rdata_a), 0);
    check("rd_drain_l2rd",  32'(l2_read_a), 0);
    check("rd_drain_busy",  32'(busy_a), 1);
    check("rd_drain_grant", 32'(grant_a), 0);
    tick();
    check("rd_idle_busy",   32'(busy_a), 0);
    check("rd_idle_resp",   32'(resp_a), 0);

    // Write with byte enables from port 1
    addr2  = {16'h0040, 16'h0000};
    wdata2 = {16'h00AA, 16'h0000};
    be2    = {2'b01, 2'b00};
    wr2    = 2'b10;
    tick();
    check("wr_grant",  32'(grant_a), 1);
    check("wr_l2_wr",  32'(l2_write_a), 1);
    check("wr_l2_rd",  32'(l2_read_a), 0);
    check("wr_be",     32'(l2_be_a), 32'h1);
    check("wr_wdata",  32'(l2_wdata_a), 32'h00AA);
    check("wr_addr",   32'(l2_addr_a), 32'h0040);
    wait_resp(0, "wr_wait");
    check("wr_resp",   32'(resp_a), 2);
    wr2 = '0; be2 = '0;
    tick(); tick();

    // Illegal read+write on port 0: only the write is forwarded
    addr2  = {16'h0000, 16'h0100};
    wdata2 = {16'h0000, 16'h5A5A};
    be2    = 4'b0011;
    rd2    = 2'b01;
    wr2    = 2'b01;
    tick();
    check("ill_l2_wr",    32'(l2_write_a), 1);
    check("ill_l2_rd",    32'(l2_read_a), 0);
    check("ill_fx_l2_rd", 32'(l2_read_b), 0);
    wait_resp(0, "ill_wait");
    rd2 = '0; wr2 = '0; be2 = '0;
    tick(); tick();

    // Reset one cycle into BUSY; rr_ptr is 1 here and must return to 0
    rd2 = 2'b10;
    tick();
    check("rstm_grant_pre", 32'(grant_a), 1);
    reset = 1'b1;
    #1;
    check("rstm_l2_rd",  32'(l2_read_a), 0);
    check("rstm_busy",   32'(busy_a), 0);
    check("rstm_grant",  32'(grant_a), 0);
    check("rstm_resp",   32'(resp_a), 0);
    tick();
    check("rstm_resp_hold", 32'(resp_a), 0);
    check("rstm_l2rd_hold", 32'(l2_read_a), 0);
    reset = 1'b0;
    rd2   = 2'b11;
    tick();
    check("rstm_rr_restart", 32'(grant_a), 0);
    check("rstm_no_resp",    32'(resp_a), 0);
    wait_resp(0, "rstm_wait");
    rd2 = '0;
    tick(); tick();

    // 3 ports: drive rr_ptr to 2, then ports 0 and 1 request -> wrap to 0, then 1
    addr3 = {16'h3333, 16'h2222, 16'h1111};
    rd3   = 3'b010;
    wait_resp(1, "p3_setup_wait");
    check("p3_setup_grant", 32'(grant_c), 1);
    rd3 = '0;
    tick(); tick();
    rd3 = 3'b011;
    tick();
    check("p3_wrap_grant", 32'(grant_c), 0);
    check("p3_wrap_addr",  32'(l2_addr_c), 32'h1111);
    wait_resp(1, "p3_wrap_wait");
    check("p3_wrap_resp",  32'(resp_c), 1);
    check("p3_wrap_rdata", 32'(rdata_c), 32'hC0DE);
    wait_resp(1, "p3_next_wait");
    check("p3_next_grant", 32'(grant_c), 1);
    check("p3_next_resp",  32'(resp_c), 2);
    rd3 = '0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
